oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Famicom sprite DMA engine; sits upstream of the CPU register file and is the source of its `stall` input.
- A CPU write to $4014 triggers a copy of 256 bytes from CPU page {value,00}..{value,FF} to PPU OAMDATA ($2004).
- While the copy runs, the CPU is frozen and this block owns the system bus.
- Drives a separate address/strobe bus; the top level muxes it onto the shared data bus whenever `stall` is high.

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every write cycle.

Ports:
- clk  in  1  system clock, one CPU cycle per edge
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  16  CPU bus address
- cpu_wr  in  1  CPU write strobe for the current cycle
- cpu_wdata  in  8  CPU write data
- dma_rdata  in  8  bus read data during DMA read cycles
- stall  out  1  freezes the CPU (register-file stall input)
- dma_addr  out  16  DMA bus address
- dma_rd  out  1  DMA read strobe
- dma_wr  out  1  DMA write strobe
- dma_wdata  out  8  data written to OAMDATA
- dma_done  out  1  one-cycle pulse on the final write cycle

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, page=0, idx=0, buf=0, phase=0.
  - All outputs 0; dma_addr=16'h0000.
  - Takes effect immediately, including mid-transfer. No partial resume after reset.
- phase: 1-bit register, toggles every clk. phase=0 is a "get" cycle; reads happen only on get cycles.
- State machine (state register; all outputs decoded from registered state, so no comb path from cpu_* to stall):
  - IDLE: stall=0, strobes=0. If cpu_wr && cpu_addr==TRIG_ADDR: page<=cpu_wdata, idx<=0, next=HALT. The trigger cycle itself is not stalled.
  - HALT (1 cycle): stall=1. If phase==1, next=READ (the next cycle is a get). Otherwise next=ALIGN.
  - ALIGN (1 cycle): stall=1, no strobes, next=READ.
  - READ: stall=1, dma_rd=1, dma_addr={page,idx}. buf<=dma_rdata at the clock edge. next=WRITE.
  - WRITE: stall=1, dma_wr=1, dma_addr=OAM_DATA_ADDR, dma_wdata=buf.
    - If idx==8'hFF: dma_done=1, next=IDLE.
    - Else idx<=idx+1, next=READ.
- Timing:
  - Total stall is 513 cycles (HALT + 256×2) or 514 cycles (with ALIGN).
  - stall rises in the cycle after the trigger write and falls in the cycle after dma_done.
- Width/wrap rules:
  - idx is 8 bits and never wraps inside a transfer; the terminal test is idx==FF.
  - Page FF reads FF00..FFFF with no carry into 16'h0000.
- Simultaneous and boundary events:
  - Trigger writes while state!=IDLE are ignored; page is unchanged.
  - A trigger in the same cycle dma_done is high is also ignored (state is not yet IDLE).
  - A trigger in the first IDLE cycle after completion starts a new transfer.
  - Writes to other addresses have no effect.
  - cpu_* inputs are don't-care while stall=1.
- dma_wdata holds buf in every state; only dma_wr qualifies it.

Decomposition:
- Shared package (enums): `oam_dma_state_t` enum {DMA_IDLE, DMA_HALT, DMA_ALIGN, DMA_READ, DMA_WRITE}, plus constants DMA_TRIG_ADDR and OAM_DATA_ADDR used as the parameter defaults.
- No sub-module: the phase toggle and index counter are inline registers. Single module, roughly 150 lines.

Test Plan:
- Write 8'h02 to $4014 with phase=1 during HALT → no ALIGN; first READ addr 16'h0200; last WRITE after 513 stall cycles; dma_done one cycle; stall low in the next cycle.
- Same trigger with phase=0 during HALT → one ALIGN cycle; 514 stall cycles; reads always on phase=0 and writes always on phase=1.
- Memory model returns addr[7:0]^8'h5A → 256 writes to 16'h2004 with dma_wdata sequence 5A,5B,58,…,A5 in order; no extra or missing dma_wr.
- Second $4014 write (8'h07) injected at READ idx 10 → ignored; all read addresses stay in page 02.
- rst_n pulsed low at idx 8'h80 → stall, dma_rd and dma_wr drop asynchronously; after release the block is IDLE and a new trigger to page 8'hFF reads FF00..FFFF.
- Write 8'h03 to 16'h4015 and a read of $4014 (cpu_wr=0) → stall stays 0 and no strobes.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite DMA engine: FSM state encoding and the
// two fixed bus addresses used as parameter defaults by oam_dma.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } oam_dma_state_t;

  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Famicom sprite DMA engine. A CPU write to TRIG_ADDR copies the 256 bytes of
// CPU page {value,00..FF} into OAMDATA, freezing the CPU via stall_o while the
// engine owns the bus. Reads only happen on "get" cycles (phase 0), so a
// transfer is HALT + 256 read/write pairs, plus one ALIGN cycle when needed.
//
// Ports:
//   clk_i         system clock, one CPU cycle per edge
//   rst_ni        asynchronous active-low reset
//   cpu_addr_i    CPU bus address
//   cpu_wr_i      CPU write strobe
//   cpu_wdata_i   CPU write data
//   dma_rdata_i   bus read data during DMA read cycles
//   stall_o       freezes the CPU
//   dma_addr_o    DMA bus address
//   dma_rd_o      DMA read strobe
//   dma_wr_o      DMA write strobe
//   dma_wdata_o   byte written to OAMDATA (qualified by dma_wr_o)
//   dma_done_o    one-cycle pulse on the final write cycle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DMA_IDLE  | waiting for a trigger write; CPU runs
// DMA_HALT  | first stalled cycle; picks READ or ALIGN from phase
// DMA_ALIGN | dummy cycle so the first read lands on a get cycle
// DMA_READ  | read {page,idx} from the bus into the byte buffer
// DMA_WRITE | write the buffer to OAMDATA; finish after idx FF
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR     = oam_dma_pkg::DMA_TRIG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = oam_dma_pkg::OAM_DATA_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_wdata_i,
  input  logic [7:0]  dma_rdata_i,
  output logic        stall_o,
  output logic [15:0] dma_addr_o,
  output logic        dma_rd_o,
  output logic        dma_wr_o,
  output logic [7:0]  dma_wdata_o,
  output logic        dma_done_o
);

  import oam_dma_pkg::*;

  oam_dma_state_t state_q, state_d;
  logic           phase_q;
  logic [7:0]     page_q, page_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     buf_q, buf_d;
  logic           trig;

  assign trig = cpu_wr_i && (cpu_addr_i == TRIG_ADDR);

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      DMA_IDLE: begin
        if (trig) begin
          page_d  = cpu_wdata_i;
          idx_d   = 8'h00;
          state_d = DMA_HALT;
        end
      end
      // phase_q toggles on this edge: phase 1 now means the next cycle is a get.
      DMA_HALT:  state_d = phase_q ? DMA_READ : DMA_ALIGN;
      DMA_ALIGN: state_d = DMA_READ;
      DMA_READ: begin
        buf_d   = dma_rdata_i;
        state_d = DMA_WRITE;
      end
      DMA_WRITE: begin
        // idx never wraps: the transfer ends on FF instead of incrementing.
        if (idx_q == 8'hFF) begin
          state_d = DMA_IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = DMA_READ;
        end
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DMA_IDLE;
      phase_q <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      buf_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= ~phase_q;
      page_q  <= page_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs depend on registered state only, so cpu_* never reaches stall_o
  // combinationally.
  always_comb begin
    stall_o    = (state_q != DMA_IDLE);
    dma_rd_o   = (state_q == DMA_READ);
    dma_wr_o   = (state_q == DMA_WRITE);
    dma_done_o = (state_q == DMA_WRITE) && (idx_q == 8'hFF);
    dma_wdata_o = buf_q;
    if (state_q == DMA_READ) begin
      dma_addr_o = {page_q, idx_q};
    end else if (state_q == DMA_WRITE) begin
      dma_addr_o = OAM_DATA_ADDR;
    end else begin
      dma_addr_o = 16'h0000;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a transfer-level model (cycles since trigger, phase
// parity) is compared against the DUT every cycle; a monitor collects
// per-transfer totals that are checked against hand-computed values.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  dma_rdata;
  logic        stall;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        dma_wr;
  logic [7:0]  dma_wdata;
  logic        dma_done;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cpu_addr_i  (cpu_addr),
    .cpu_wr_i    (cpu_wr),
    .cpu_wdata_i (cpu_wdata),
    .dma_rdata_i (dma_rdata),
    .stall_o     (stall),
    .dma_addr_o  (dma_addr),
    .dma_rd_o    (dma_rd),
    .dma_wr_o    (dma_wr),
    .dma_wdata_o (dma_wdata),
    .dma_done_o  (dma_done)
  );

  // Memory: byte at any address is its low byte XOR 5A.
  assign dma_rdata = dma_addr[7:0] ^ 8'h5A;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transfer-level model: active for 513 (+1 when aligning) cycles after a
  // trigger accepted while idle; after HALT/ALIGN the cycles alternate read,
  // write for bytes 0..255.
  logic       m_active;
  logic       m_phase;
  logic       m_align;
  int         m_rel;
  logic [7:0] m_page;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_phase  <= 1'b0;
      m_align  <= 1'b0;
      m_rel    <= 0;
      m_page   <= 8'h00;
    end else begin
      m_phase <= ~m_phase;
      if (m_active) begin
        if (m_rel == 512 + int'(m_align)) m_active <= 1'b0;
        else m_rel <= m_rel + 1;
      end else if (cpu_wr && cpu_addr == 16'h4014) begin
        m_active <= 1'b1;
        m_rel    <= 0;
        m_page   <= cpu_wdata;
        // HALT runs with the toggled phase; a phase-0 HALT needs an extra cycle.
        m_align  <= m_phase;
      end
    end
  end

  always @(negedge clk) begin
    int          k;
    logic        e_rd, e_wr, e_done;
    logic [15:0] e_addr;
    k      = m_rel - 1 - int'(m_align);
    e_rd   = m_active && k >= 0 && (k % 2 == 0);
    e_wr   = m_active && k >= 0 && (k % 2 == 1);
    e_addr = e_rd ? {m_page, 8'(k / 2)} : (e_wr ? 16'h2004 : 16'h0000);
    e_done = e_wr && (k / 2 == 255);
    check("cycle {stall,rd,wr,done,addr}",
          32'({stall, dma_rd, dma_wr, dma_done, dma_addr}),
          32'({m_active, e_rd, e_wr, e_done, e_addr}));
    if (e_wr) check("wdata", 32'(dma_wdata), 32'(8'(k / 2) ^ 8'h5A));
  end

  // Per-transfer monitor.
  int          mon_stall, mon_rd, mon_wr, mon_done, mon_badpage, mon_badphase;
  logic [15:0] mon_first_rd, mon_last_rd;
  logic [7:0]  mon_page;
  logic [7:0]  mon_wd [0:255];

  always @(negedge clk) begin
    if (stall) mon_stall++;
    if (dma_rd) begin
      if (mon_rd == 0) mon_first_rd = dma_addr;
      mon_last_rd = dma_addr;
      mon_rd++;
      if (dma_addr[15:8] != mon_page) mon_badpage++;
      if (m_phase != 1'b0) mon_badphase++;
    end
    if (dma_wr) begin
      if (mon_wr < 256) mon_wd[mon_wr] = dma_wdata;
      mon_wr++;
      if (m_phase != 1'b1) mon_badphase++;
    end
    if (dma_done) mon_done++;
  end

  task automatic clear_mon(input logic [7:0] page);
    mon_stall = 0; mon_rd = 0; mon_wr = 0; mon_done = 0;
    mon_badpage = 0; mon_badphase = 0;
    mon_first_rd = 16'h0; mon_last_rd = 16'h0;
    mon_page = page;
  endtask

  // Issue a trigger so that the following HALT cycle has the requested phase.
  task automatic trigger(input logic [7:0] page, input logic halt_phase);
    @(posedge clk); #1;
    if (m_phase == halt_phase) begin
      @(posedge clk); #1;
    end
    cpu_addr = 16'h4014; cpu_wdata = page; cpu_wr = 1'b1;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(mon_done > 0 && !stall) && n < 800) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 800) check({name, " timeout"}, 32'(n), 32'(0));
  endtask

  task automatic wait_neg(input string name, input logic [15:0] addr, input logic want_done);
    int n = 0;
    @(negedge clk); #1;
    while (!(want_done ? dma_done : (dma_rd && dma_addr == addr)) && n < 800) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 800) check({name, " timeout"}, 32'(n), 32'(0));
  endtask

  int seq_bad;

  initial begin
    rst_n = 1'b0; cpu_addr = 16'h0; cpu_wr = 1'b0; cpu_wdata = 8'h0;
    clear_mon(8'h00);
    #12;
    check("reset stall", 32'(stall), 32'(0));
    check("reset addr", 32'(dma_addr), 32'(16'h0000));
    check("reset strobes", 32'({dma_rd, dma_wr, dma_done}), 32'(0));
    check("reset wdata", 32'(dma_wdata), 32'(8'h00));
    #10 rst_n = 1'b1;

    // Transfer with phase 1 in HALT: no ALIGN, 513 stall cycles.
    clear_mon(8'h02);
    trigger(8'h02, 1'b1);
    wait_idle("t1");
    check("t1 stall cycles", 32'(mon_stall), 32'(513));
    check("t1 first read", 32'(mon_first_rd), 32'(16'h0200));
    check("t1 last read", 32'(mon_last_rd), 32'(16'h02FF));
    check("t1 writes", 32'(mon_wr), 32'(256));
    check("t1 reads", 32'(mon_rd), 32'(256));
    check("t1 done pulses", 32'(mon_done), 32'(1));
    check("t1 wd0", 32'(mon_wd[0]), 32'(8'h5A));
    check("t1 wd1", 32'(mon_wd[1]), 32'(8'h5B));
    check("t1 wd2", 32'(mon_wd[2]), 32'(8'h58));
    check("t1 wd255", 32'(mon_wd[255]), 32'(8'hA5));
    seq_bad = 0;
    for (int i = 0; i < 256; i++) if (mon_wd[i] != (8'(i) ^ 8'h5A)) seq_bad++;
    check("t1 wdata sequence", 32'(seq_bad), 32'(0));
    check("t1 phase alignment", 32'(mon_badphase), 32'(0));
    check("t1 stall after done", 32'(stall), 32'(0));

    // Transfer with phase 0 in HALT: one ALIGN cycle, 514 stall cycles.
    clear_mon(8'h02);
    trigger(8'h02, 1'b0);
    wait_idle("t2");
    check("t2 stall cycles", 32'(mon_stall), 32'(514));
    check("t2 writes", 32'(mon_wr), 32'(256));
    check("t2 first read", 32'(mon_first_rd), 32'(16'h0200));
    check("t2 phase alignment", 32'(mon_badphase), 32'(0));

    // Retrigger at idx 0A and on the done cycle are ignored; a trigger in the
    // first idle cycle afterwards starts a new transfer.
    clear_mon(8'h02);
    trigger(8'h02, 1'b1);
    wait_neg("t3 idx0A", 16'h020A, 1'b0);
    cpu_addr = 16'h4014; cpu_wdata = 8'h07; cpu_wr = 1'b1;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    wait_neg("t3 done", 16'h0000, 1'b1);
    check("t3 reads stay in page 02", 32'(mon_badpage), 32'(0));
    check("t3 writes", 32'(mon_wr), 32'(256));
    cpu_addr = 16'h4014; cpu_wdata = 8'h09; cpu_wr = 1'b1;
    @(posedge clk); #1;
    check("t3 first idle cycle stall", 32'(stall), 32'(0));
    cpu_wdata = 8'h05;
    clear_mon(8'h05);
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    check("t3 back-to-back stall", 32'(stall), 32'(1));
    wait_idle("t3b");
    check("t3b first read", 32'(mon_first_rd), 32'(16'h0500));
    check("t3b bad page", 32'(mon_badpage), 32'(0));
    check("t3b writes", 32'(mon_wr), 32'(256));

    // Asynchronous reset mid-transfer, then a page FF transfer.
    clear_mon(8'h02);
    trigger(8'h02, 1'b1);
    wait_neg("t4 idx80", 16'h0280, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t4 async stall", 32'(stall), 32'(0));
    check("t4 async strobes", 32'({dma_rd, dma_wr}), 32'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    clear_mon(8'hFF);
    trigger(8'hFF, 1'b1);
    wait_idle("t4b");
    check("t4b first read", 32'(mon_first_rd), 32'(16'hFF00));
    check("t4b last read", 32'(mon_last_rd), 32'(16'hFFFF));
    check("t4b bad page", 32'(mon_badpage), 32'(0));
    check("t4b writes", 32'(mon_wr), 32'(256));
    check("t4b stall cycles", 32'(mon_stall), 32'(513));

    // Non-trigger accesses.
    clear_mon(8'h00);
    @(posedge clk); #1;
    cpu_addr = 16'h4015; cpu_wdata = 8'h03; cpu_wr = 1'b1;
    @(posedge clk); #1;
    cpu_addr = 16'h4014; cpu_wdata = 8'h07; cpu_wr = 1'b0;
    @(posedge clk); #1;
    cpu_addr = 16'h0000;
    repeat (5) @(posedge clk);
    #1;
    check("t5 stall cycles", 32'(mon_stall), 32'(0));
    check("t5 strobes", 32'(mon_rd + mon_wr), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
